truth_table_sweeper: RTL

Sequencing controller for the 4-input / 2-output combinational logic blocks built in the lab (inputs a, b, c, d; outputs f, g). On a start request it drives all 2^N_IN input vectors in ascending order onto the function under test. After each vector it waits a programmable settle time, then samples both outputs. It assembles the complete truth tables for f and g, counts the minterms, and signals completion. The function under test sits outside this block and connects between `vec_out` and `fg_in`.

---
 rtl/truth_table_sweeper_pkg.sv | 21 ++
 rtl/truth_table_sweeper_settle_timer.sv | 40 ++++
 rtl/truth_table_sweeper.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding, fg_in bit
// positions and the settle-counter width rule.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Position of each function output within fg_in.
  localparam int unsigned F_BIT = 1;
  localparam int unsigned G_BIT = 0;

  // Settle counter holds SETTLE-1; one spare bit keeps SETTLE=1 at width 1.
  function automatic int unsigned settle_cnt_w(input int unsigned settle);
    return $clog2(settle) + 1;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter with enable; zero flag marks the end of a settle window.
module settle_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge value, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps all 2^N_IN input vectors through an external function, waits SETTLE
// cycles per vector, samples f/g and assembles both truth tables with counts.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 hold,
  input  logic [1:0]           fg_in,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic [(1<<N_IN)-1:0] table_f,
  output logic [(1<<N_IN)-1:0] table_g,
  output logic [N_IN:0]        ones_f,
  output logic [N_IN:0]        ones_g
);

  localparam int unsigned NV = 1 << N_IN;
  localparam int unsigned CW = settle_cnt_w(SETTLE);
  localparam logic [N_IN-1:0] LAST_VEC  = '1;
  localparam logic [CW-1:0]   SETTLE_LD = CW'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [NV-1:0]   table_f_q, table_f_d;
  logic [NV-1:0]   table_g_q, table_g_d;
  logic [N_IN:0]   ones_f_q, ones_f_d;
  logic [N_IN:0]   ones_g_q, ones_g_d;

  logic            timer_load;
  logic            timer_en;
  logic            timer_zero;
  logic [CW-1:0]   timer_cnt;

  settle_timer #(.W(CW)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LD),
    .en       (timer_en),
    .cnt      (timer_cnt),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    table_f_d  = table_f_q;
    table_g_d  = table_g_q;
    ones_f_d   = ones_f_q;
    ones_g_d   = ones_g_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_WAIT;
          vec_d      = '0;
          table_f_d  = '0;
          table_g_d  = '0;
          ones_f_d   = '0;
          ones_g_d   = '0;
          timer_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!hold) begin
          if (timer_zero) begin
            state_d = ST_SAMPLE;
          end else begin
            timer_en = 1'b1;
          end
        end
      end
      ST_SAMPLE: begin
        // Held SAMPLE repeats without capturing, so each hold cycle costs one.
        if (!hold) begin
          table_f_d[vec_q] = fg_in[F_BIT];
          table_g_d[vec_q] = fg_in[G_BIT];
          ones_f_d = ones_f_q + {{N_IN{1'b0}}, fg_in[F_BIT]};
          ones_g_d = ones_g_q + {{N_IN{1'b0}}, fg_in[G_BIT]};
          if (vec_q == LAST_VEC) begin
            state_d = ST_DONE;
          end else begin
            vec_d      = vec_q + 1'b1;
            timer_load = 1'b1;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flags decode the next state so the outputs themselves stay registered.
    busy_d = (state_d == ST_WAIT) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      table_f_q <= '0;
      table_g_q <= '0;
      ones_f_q  <= '0;
      ones_g_q  <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      table_f_q <= table_f_d;
      table_g_q <= table_g_d;
      ones_f_q  <= ones_f_d;
      ones_g_q  <= ones_g_d;
    end
  end

  assign vec_out = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign table_f = table_f_q;
  assign table_g = table_g_q;
  assign ones_f  = ones_f_q;
  assign ones_g  = ones_g_q;

endmodule
